// File: rtl/int_result_router.sv
// Round-robin arbiter routing per-lane intersection results into a list FIFO and a larb FIFO.
// Optional hit/miss statistics counters are enabled with the INT_ROUTER_STATS_EN macro.
module int_result_router #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RAYID_W   = 9,
    parameter int unsigned TRI_W     = 16,
    parameter int unsigned LIDX_W    = 16,
    parameter int unsigned LNUM_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          in_valid,
    output logic [NUM_LANES-1:0]          in_stall,
    input  logic [NUM_LANES*RAYID_W-1:0]  in_rayID,
    input  logic [NUM_LANES-1:0]          in_hit,
    input  logic [NUM_LANES*32-1:0]       in_t_int,
    input  logic [NUM_LANES*32-1:0]       in_u,
    input  logic [NUM_LANES*32-1:0]       in_v,
    input  logic [NUM_LANES*TRI_W-1:0]    in_triID,
    input  logic [NUM_LANES*LIDX_W-1:0]   in_lindex,
    input  logic [NUM_LANES*LNUM_W-1:0]   in_lnum_left,
    output logic                          list_valid,
    input  logic                          list_stall,
    output logic [RAYID_W-1:0]            list_rayID,
    output logic                          list_hit,
    output logic [TRI_W-1:0]              list_triID,
    output logic [31:0]                   list_t_int,
    output logic [31:0]                   list_u,
    output logic [31:0]                   list_v,
    output logic                          larb_valid,
    input  logic                          larb_stall,
    output logic [RAYID_W-1:0]            larb_rayID,
    output logic [LIDX_W-1:0]             larb_lindex,
    output logic [LNUM_W-1:0]             larb_lnum_left
`ifdef INT_ROUTER_STATS_EN
    ,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef struct packed {
        logic [RAYID_W-1:0] ray;
        logic               hit;
        logic [TRI_W-1:0]   triid;
        logic [31:0]        t;
        logic [31:0]        u;
        logic [31:0]        v;
    } list_ent_t;

    typedef struct packed {
        logic [RAYID_W-1:0] ray;
        logic [LIDX_W-1:0]  lidx;
        logic [LNUM_W-1:0]  lnum;
    } larb_ent_t;

    list_ent_t          r_list_mem [DEPTH];
    logic [PTR_W-1:0]   r_list_wr, r_list_rd;
    logic [CNT_W-1:0]   r_list_cnt;
    larb_ent_t          r_larb_mem [DEPTH];
    logic [PTR_W-1:0]   r_larb_wr, r_larb_rd;
    logic [CNT_W-1:0]   r_larb_cnt;
    logic [RR_W-1:0]    r_rr;

    logic               w_list_pop, w_list_space, w_larb_pop, w_larb_space;
    logic [NUM_LANES-1:0] w_elig, w_gnt;
    logic               w_gnt_any;
    logic [RR_W-1:0]    w_rr_next;
    logic [RAYID_W-1:0] w_sel_ray;
    logic               w_sel_hit;
    logic [TRI_W-1:0]   w_sel_tri;
    logic [31:0]        w_sel_t, w_sel_u, w_sel_v;
    logic [LIDX_W-1:0]  w_sel_lidx;
    logic [LNUM_W-1:0]  w_sel_lnum;
    logic               w_push_list, w_push_larb;
    list_ent_t          w_list_din;
    larb_ent_t          w_larb_din;

    // A full FIFO still has space when its head leaves on this same edge.
    assign w_list_pop   = (r_list_cnt != '0) & ~list_stall;
    assign w_larb_pop   = (r_larb_cnt != '0) & ~larb_stall;
    assign w_list_space = (r_list_cnt != CNT_W'(DEPTH)) | w_list_pop;
    assign w_larb_space = (r_larb_cnt != CNT_W'(DEPTH)) | w_larb_pop;

    always_comb begin
        logic v_nz;
        v_nz   = 1'b0;
        w_elig = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            v_nz      = |in_lnum_left[i*LNUM_W +: LNUM_W];
            w_elig[i] = in_valid[i]
                      & (~(in_hit[i] | ~v_nz) | w_list_space)
                      & (~v_nz | w_larb_space);
        end
    end

    // Pick the eligible lane with the smallest rotated distance from r_rr.
    always_comb begin
        int unsigned v_best;
        int unsigned v_sel;
        int unsigned v_d;
        v_best    = NUM_LANES;
        v_sel     = 0;
        v_d       = 0;
        w_gnt_any = 1'b0;
        w_gnt     = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            v_d = (i + NUM_LANES - 32'(r_rr)) % NUM_LANES;
            if (w_elig[i] && (v_d < v_best)) begin
                v_best = v_d;
                v_sel  = i;
            end
        end
        w_gnt_any = (v_best != NUM_LANES);
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_gnt[i] = w_gnt_any && (v_sel == i);
        end
        w_rr_next = w_gnt_any ? RR_W'((v_sel + 1) % NUM_LANES) : r_rr;
    end

    always_comb begin
        w_sel_ray  = '0;
        w_sel_hit  = 1'b0;
        w_sel_tri  = '0;
        w_sel_t    = '0;
        w_sel_u    = '0;
        w_sel_v    = '0;
        w_sel_lidx = '0;
        w_sel_lnum = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (w_gnt[i]) begin
                w_sel_ray  = in_rayID[i*RAYID_W +: RAYID_W];
                w_sel_hit  = in_hit[i];
                w_sel_tri  = in_triID[i*TRI_W +: TRI_W];
                w_sel_t    = in_t_int[i*32 +: 32];
                w_sel_u    = in_u[i*32 +: 32];
                w_sel_v    = in_v[i*32 +: 32];
                w_sel_lidx = in_lindex[i*LIDX_W +: LIDX_W];
                w_sel_lnum = in_lnum_left[i*LNUM_W +: LNUM_W];
            end
        end
    end

    assign w_push_list = w_gnt_any & (w_sel_hit | ~(|w_sel_lnum));
    assign w_push_larb = w_gnt_any & (|w_sel_lnum);
    assign w_list_din  = '{ray: w_sel_ray, hit: w_sel_hit, triid: w_sel_tri,
                           t: w_sel_t, u: w_sel_u, v: w_sel_v};
    assign w_larb_din  = '{ray: w_sel_ray, lidx: w_sel_lidx + LIDX_W'(1),
                           lnum: w_sel_lnum - LNUM_W'(1)};
    assign in_stall    = in_valid & ~w_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr       <= '0;
            r_list_wr  <= '0;
            r_list_rd  <= '0;
            r_list_cnt <= '0;
            r_larb_wr  <= '0;
            r_larb_rd  <= '0;
            r_larb_cnt <= '0;
        end else begin
            r_rr <= w_rr_next;
            if (w_push_list) r_list_wr <= r_list_wr + PTR_W'(1);
            if (w_list_pop)  r_list_rd <= r_list_rd + PTR_W'(1);
            if (w_push_list && !w_list_pop)      r_list_cnt <= r_list_cnt + CNT_W'(1);
            else if (!w_push_list && w_list_pop) r_list_cnt <= r_list_cnt - CNT_W'(1);
            if (w_push_larb) r_larb_wr <= r_larb_wr + PTR_W'(1);
            if (w_larb_pop)  r_larb_rd <= r_larb_rd + PTR_W'(1);
            if (w_push_larb && !w_larb_pop)      r_larb_cnt <= r_larb_cnt + CNT_W'(1);
            else if (!w_push_larb && w_larb_pop) r_larb_cnt <= r_larb_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_list) r_list_mem[r_list_wr] <= w_list_din;
        if (w_push_larb) r_larb_mem[r_larb_wr] <= w_larb_din;
    end

    assign list_valid     = (r_list_cnt != '0);
    assign list_rayID     = r_list_mem[r_list_rd].ray;
    assign list_hit       = r_list_mem[r_list_rd].hit;
    assign list_triID     = r_list_mem[r_list_rd].triid;
    assign list_t_int     = r_list_mem[r_list_rd].t;
    assign list_u         = r_list_mem[r_list_rd].u;
    assign list_v         = r_list_mem[r_list_rd].v;
    assign larb_valid     = (r_larb_cnt != '0);
    assign larb_rayID     = r_larb_mem[r_larb_rd].ray;
    assign larb_lindex    = r_larb_mem[r_larb_rd].lidx;
    assign larb_lnum_left = r_larb_mem[r_larb_rd].lnum;

`ifdef INT_ROUTER_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_gnt_any && w_sel_hit)                     r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_gnt_any && !w_sel_hit && !(|w_sel_lnum))  r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    // Statistics disabled: no counter state and no counter ports.
`endif

endmodule

// File: tb/tb_int_result_router.sv
// Randomized and directed bench for int_result_router against a queue-based reference model.
module tb_int_result_router;

    localparam int NL = 4;
    localparam int D  = 4;
    localparam int RW = 9;
    localparam int TW = 16;
    localparam int LW = 16;
    localparam int NW = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NL-1:0]      in_valid, in_stall, in_hit;
    logic [NL*RW-1:0]   in_rayID;
    logic [NL*32-1:0]   in_t_int, in_u, in_v;
    logic [NL*TW-1:0]   in_triID;
    logic [NL*LW-1:0]   in_lindex;
    logic [NL*NW-1:0]   in_lnum_left;
    logic               list_valid, list_stall, list_hit;
    logic [RW-1:0]      list_rayID;
    logic [TW-1:0]      list_triID;
    logic [31:0]        list_t_int, list_u, list_v;
    logic               larb_valid, larb_stall;
    logic [RW-1:0]      larb_rayID;
    logic [LW-1:0]      larb_lindex;
    logic [NW-1:0]      larb_lnum_left;
`ifdef INT_ROUTER_STATS_EN
    logic [31:0]        hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    int_result_router #(
        .NUM_LANES(NL), .DEPTH(D), .RAYID_W(RW), .TRI_W(TW), .LIDX_W(LW), .LNUM_W(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_stall(in_stall), .in_rayID(in_rayID), .in_hit(in_hit),
        .in_t_int(in_t_int), .in_u(in_u), .in_v(in_v), .in_triID(in_triID),
        .in_lindex(in_lindex), .in_lnum_left(in_lnum_left),
        .list_valid(list_valid), .list_stall(list_stall), .list_rayID(list_rayID),
        .list_hit(list_hit), .list_triID(list_triID), .list_t_int(list_t_int),
        .list_u(list_u), .list_v(list_v),
        .larb_valid(larb_valid), .larb_stall(larb_stall), .larb_rayID(larb_rayID),
        .larb_lindex(larb_lindex), .larb_lnum_left(larb_lnum_left)
`ifdef INT_ROUTER_STATS_EN
        ,
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {
        logic [RW-1:0] ray;
        logic          hit;
        logic [TW-1:0] triid;
        logic [31:0]   t, u, v;
    } lent_t;

    typedef struct {
        logic [RW-1:0] ray;
        logic [LW-1:0] lidx;
        logic [NW-1:0] lnum;
    } aent_t;

    lent_t       lq[$];
    aent_t       aq[$];
    int          m_rr;
    int unsigned m_hits, m_miss;
    logic [NL-1:0] m_stall;
    int          n_checks, n_errors;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input bit v, input bit h, input logic [NW-1:0] n,
                            input logic [LW-1:0] li, input logic [31:0] t);
        in_valid[i]              = v;
        in_hit[i]                = h;
        in_lnum_left[i*NW +: NW] = n;
        in_lindex[i*LW +: LW]    = li;
        in_t_int[i*32 +: 32]     = t;
        in_rayID[i*RW +: RW]     = RW'($urandom);
        in_triID[i*TW +: TW]     = TW'($urandom);
        in_u[i*32 +: 32]         = $urandom;
        in_v[i*32 +: 32]         = $urandom;
    endtask

    task automatic rand_lane(input int i);
        logic [NW-1:0] n;
        logic [LW-1:0] li;
        n  = ($urandom_range(0, 2) == 0) ? NW'(0) : NW'($urandom);
        li = ($urandom_range(0, 5) == 0) ? LW'(16'hFFFF) : LW'($urandom);
        set_lane(i, $urandom_range(0, 9) < 7, 1'($urandom), n, li, $urandom);
    endtask

    // One clock: compare outputs at negedge, predict the grant, update the model at posedge.
    task automatic step();
        bit pop_l, pop_a, sp_l, sp_a, nz, need_l;
        int g;
        lent_t le;
        aent_t ae;
        @(negedge clk);
        check("list_valid", list_valid, lq.size() != 0);
        if (lq.size() != 0)
            check("list_head", {list_rayID, list_hit, list_triID, list_t_int, list_u, list_v},
                  {lq[0].ray, lq[0].hit, lq[0].triid, lq[0].t, lq[0].u, lq[0].v});
        check("larb_valid", larb_valid, aq.size() != 0);
        if (aq.size() != 0)
            check("larb_head", {larb_rayID, larb_lindex, larb_lnum_left},
                  {aq[0].ray, aq[0].lidx, aq[0].lnum});
`ifdef INT_ROUTER_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_miss);
`endif
        pop_l = (lq.size() != 0) && !list_stall;
        pop_a = (aq.size() != 0) && !larb_stall;
        sp_l  = (lq.size() < D) || pop_l;
        sp_a  = (aq.size() < D) || pop_a;
        g = -1;
        for (int k = 0; k < NL; k++) begin
            int i;
            i      = (m_rr + k) % NL;
            nz     = in_lnum_left[i*NW +: NW] != 0;
            need_l = in_hit[i] || !nz;
            if (g < 0 && in_valid[i] && (!need_l || sp_l) && (!nz || sp_a)) g = i;
        end
        m_stall = in_valid;
        if (g >= 0) m_stall[g] = 1'b0;
        check("in_stall", in_stall, m_stall);
        if (g >= 0) begin
            le = '{in_rayID[g*RW +: RW], in_hit[g], in_triID[g*TW +: TW],
                   in_t_int[g*32 +: 32], in_u[g*32 +: 32], in_v[g*32 +: 32]};
            ae = '{in_rayID[g*RW +: RW], in_lindex[g*LW +: LW] + LW'(1),
                   in_lnum_left[g*NW +: NW] - NW'(1)};
            nz = in_lnum_left[g*NW +: NW] != 0;
        end
        @(posedge clk);
        if (!rst) begin
            lq.delete();
            aq.delete();
            m_rr   = 0;
            m_hits = 0;
            m_miss = 0;
        end else begin
            if (pop_l) void'(lq.pop_front());
            if (pop_a) void'(aq.pop_front());
            if (g >= 0) begin
                if (le.hit || !nz) lq.push_back(le);
                if (nz) aq.push_back(ae);
                if (le.hit) m_hits++;
                else if (!nz) m_miss++;
                m_rr = (g + 1) % NL;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        m_rr = 0; m_hits = 0; m_miss = 0; m_stall = '0;
        in_valid = '0; in_hit = '0; in_rayID = '0; in_t_int = '0; in_u = '0; in_v = '0;
        in_triID = '0; in_lindex = '0; in_lnum_left = '0;
        list_stall = 1'b0; larb_stall = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        check("rst_list_valid", list_valid, 1'b0);
        check("rst_larb_valid", larb_valid, 1'b0);

        // Single hit with nothing left in the leaf goes only to the list FIFO.
        set_lane(0, 1, 1, 0, 16'h0000, 32'h40400000);
        step();
        in_valid = '0;
        check("hit_t_int", list_t_int, 32'h40400000);
        check("hit_flag", list_hit, 1'b1);
        check("hit_no_larb", larb_valid, 1'b0);
        step();

        // Miss with triangles left: index wraps, count decrements.
        set_lane(1, 1, 0, 3, 16'hFFFF, 32'h0);
        step();
        in_valid = '0;
        check("wrap_lindex", larb_lindex, 16'h0000);
        check("wrap_lnum", larb_lnum_left, 5'd2);
        check("wrap_no_list", list_valid, 1'b0);
        step();

        // Hit needing both FIFOs waits for the full larb FIFO, then enters both on one edge.
        larb_stall = 1'b1;
        for (int k = 0; k < D; k++) begin
            set_lane(0, 1, 0, 1, LW'(k), 32'h0);
            step();
        end
        set_lane(0, 1, 1, 1, 16'h0010, 32'h3F800000);
        step();
        #1;
        check("both_stalled", in_stall[0], 1'b1);
        check("both_list_empty", list_valid, 1'b0);
        larb_stall = 1'b0;
        step();
        larb_stall = 1'b1;
        in_valid = '0;
        check("both_list", list_valid, 1'b1);
        check("both_list_t", list_t_int, 32'h3F800000);
        larb_stall = 1'b0;
        for (int k = 0; k < D + 2; k++) step();

        // Round-robin order with all lanes continuously eligible.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NL; i++) set_lane(i, 1, 1, 0, 16'h0, $urandom);
            #1;
            check("rr_order", in_stall, NL'(4'hF & ~(4'b0001 << (k % NL))));
            step();
        end
        in_valid = '0;
        for (int k = 0; k < D + 2; k++) step();

        // Full list FIFO back-pressures, then push and pop on the same edge.
        list_stall = 1'b1;
        for (int k = 0; k < D; k++) begin
            set_lane(2, 1, 1, 0, 16'h0, 32'(k));
            step();
        end
        set_lane(2, 1, 1, 0, 16'h0, 32'h55);
        #1;
        check("full_stall", in_stall[2], 1'b1);
        step();
        list_stall = 1'b0;
        step();
        in_valid = '0;
        for (int k = 0; k < D + 2; k++) step();

        // Reset with entries queued discards them; rr restarts at lane 0.
        list_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_lane(1, 1, 1, 0, 16'h0, 32'(k));
            step();
        end
        in_valid = '0;
        do_reset();
        list_stall = 1'b0;
        check("mid_rst_list", list_valid, 1'b0);
        check("mid_rst_larb", larb_valid, 1'b0);
`ifdef INT_ROUTER_STATS_EN
        check("mid_rst_hits", hit_cnt, 32'd0);
`endif
        set_lane(1, 1, 1, 0, 16'h0, 32'h1);
        set_lane(2, 1, 0, 0, 16'h0, 32'h2);
        #1;
        check("post_rst_grant", in_stall, 4'b0100);
        step();
        in_valid = '0;
        step();
        step();

        // Random traffic with lanes holding stalled results.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NL; i++)
                if (!(in_valid[i] && m_stall[i])) rand_lane(i);
            list_stall = ($urandom_range(0, 9) < 3);
            larb_stall = ($urandom_range(0, 9) < 3);
            step();
        end
        in_valid = '0;
        list_stall = 1'b0;
        larb_stall = 1'b0;
        for (int k = 0; k < D + 2; k++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
